// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state encoding and default sizing for the config loader
//
// Purpose: FSM state type and default parameter values shared by config_loader
//          and config_word_serializer.
// Ports:   none (package).
package config_pkg;

  localparam int unsigned DEF_WORD_WIDTH   = 8;
  localparam int unsigned DEF_CHAIN_LENGTH = 24;
  localparam int unsigned DEF_CLEAR_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/config_word_serializer.sv
// rtl/config_word_serializer.sv - one-word buffer that shifts a config word out MSB-first
//
// Purpose: holds one host word and presents one bit per cycle, MSB first, for
//          nbits_i bits; lower bits beyond nbits_i are never presented.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   load_i         capture word_i/nbits_i this cycle (only when empty or on last bit)
//   word_i         word to serialize
//   nbits_i        number of upper bits of word_i to emit
//   bit_o          registered current bit (0 whenever valid_o is low)
//   valid_o        registered: bit_o is a real chain bit this cycle
//   last_o         current bit is the last bit of the buffered word
//   ready_next_o   next cycle the buffer will be empty or on its last bit
module config_word_serializer
  import config_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned CNT_W      = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [CNT_W-1:0]      nbits_i,
  output logic                  bit_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic                  ready_next_o
);

  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      sreg_d  = word_i;
      cnt_d   = nbits_i;
      valid_d = (nbits_i != '0);
    end else if (valid_q) begin
      if (cnt_q == CNT_W'(1)) begin
        // Zero the register so chain_data reads 0 while the buffer is empty,
        // including the discarded low bits of a truncated final word.
        sreg_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        sreg_d = {sreg_q[WORD_WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bit_o        = sreg_q[WORD_WIDTH-1];
  assign valid_o      = valid_q;
  assign last_o       = valid_q && (cnt_q == CNT_W'(1));
  assign ready_next_o = !valid_d || (cnt_d == CNT_W'(1));

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - loads host config words serially into a downstream shift chain
//
// Purpose: on start, clears the chain for CLEAR_CYCLES cycles, then accepts
//          ceil(CHAIN_LENGTH/WORD_WIDTH) host words and shifts exactly
//          CHAIN_LENGTH bits MSB-first into the chain, then pulses done.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   start                        one-cycle load request (ignored unless idle)
//   word_data/word_valid/word_ready  host word handshake
//   chain_data/chain_enable      serial bit and shift enable to the chain
//   chain_nreset                 active-low chain clear
//   busy                         load in progress (CLEAR or SHIFT)
//   done                         one-cycle pulse after the last chain bit
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int unsigned CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_WORDS  = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned TAIL_BITS  = CHAIN_LENGTH % WORD_WIDTH;
  localparam int unsigned BIT_CNT_W  = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned WORD_CNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned CLR_CNT_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned SER_CNT_W  = $clog2(WORD_WIDTH + 1);

  state_e                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CLR_CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic                  word_ready_q, word_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  nreset_q, nreset_d;

  logic                  accept;
  logic                  last_bit;
  logic [SER_CNT_W-1:0]  load_nbits;
  logic                  ser_bit, ser_valid, ser_last, ser_ready_next;

  assign accept = word_valid && word_ready_q;

  // Final word of a chain that is not a whole number of words only
  // contributes its upper TAIL_BITS bits.
  assign load_nbits = ((TAIL_BITS != 0) && (word_cnt_q == WORD_CNT_W'(NUM_WORDS - 1)))
                    ? SER_CNT_W'(TAIL_BITS) : SER_CNT_W'(WORD_WIDTH);

  // The final chain bit is always the last bit of the final word.
  assign last_bit = ser_last && (bit_cnt_q == BIT_CNT_W'(CHAIN_LENGTH - 1));

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_W      (SER_CNT_W)
  ) u_serializer (
    .clock        (clock),
    .reset        (reset),
    .load_i       (accept),
    .word_i       (word_data),
    .nbits_i      (load_nbits),
    .bit_o        (ser_bit),
    .valid_o      (ser_valid),
    .last_o       (ser_last),
    .ready_next_o (ser_ready_next)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          clr_cnt_d  = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = ST_SHIFT;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
        end
        // Counter only advances on cycles that actually emit a bit, so a
        // host underrun stalls it without losing or repeating bits.
        if (ser_valid) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from next-state so they line up with the state.
    // word_ready is raised one cycle ahead when the buffer will be free (or on
    // its last bit) so a continuously valid host sees no enable gaps.
    word_ready_d = (state_d == ST_SHIFT) && ser_ready_next
                && (word_cnt_d < WORD_CNT_W'(NUM_WORDS));
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_SHIFT);
    done_d       = (state_d == ST_DONE);
    nreset_d     = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nreset_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nreset_q     <= nreset_d;
    end
  end

  assign word_ready   = word_ready_q;
  assign chain_data   = ser_bit;
  assign chain_enable = ser_valid;
  assign chain_nreset = nreset_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - self-checking bench for config_loader
module tb_config_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;
  logic [7:0] word_data;
  logic       word_valid;
  logic       start24, start20;

  logic wr24, cd24, ce24, nr24, busy24, done24;
  logic wr20, cd20, ce20, nr20, busy20, done20;
  logic word_ready, chain_data, chain_enable, chain_nreset, busy, done;

  logic [7:0] words [4];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign start24      = start & ~sel;
  assign start20      = start & sel;
  assign word_ready   = sel ? wr20   : wr24;
  assign chain_data   = sel ? cd20   : cd24;
  assign chain_enable = sel ? ce20   : ce24;
  assign chain_nreset = sel ? nr20   : nr24;
  assign busy         = sel ? busy20 : busy24;
  assign done         = sel ? done20 : done24;

  config_loader u_dut24 (
    .clock(clock), .reset(reset), .start(start24),
    .word_data(word_data), .word_valid(word_valid), .word_ready(wr24),
    .chain_data(cd24), .chain_enable(ce24), .chain_nreset(nr24),
    .busy(busy24), .done(done24)
  );

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .CLEAR_CYCLES(2)) u_dut20 (
    .clock(clock), .reset(reset), .start(start20),
    .word_data(word_data), .word_valid(word_valid), .word_ready(wr20),
    .chain_data(cd20), .chain_enable(ce20), .chain_nreset(nr20),
    .busy(busy20), .done(done20)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete load. The host offers one word more than the chain needs;
  // the expected bitstream is the words concatenated MSB-first, cut to cl bits.
  task automatic run_load(input int cl, input int stall_len, input bit rand_valid,
                          input bit start_pulses, input int reset_after,
                          input logic [31:0] exp_rb);
    int nw, idx, nbits, nen, ndone, nclr, first_en, last_en, after_done, stall_left;
    bit exp_bits[$];
    bit stalled, v;
    logic [31:0] rb;
    nw = (cl + 7) / 8;
    exp_bits = {};
    for (int i = 0; i < cl; i++) exp_bits.push_back(words[i / 8][7 - (i % 8)]);
    idx = 0; nbits = 0; nen = 0; ndone = 0; nclr = 0;
    first_en = -1; last_en = -1; after_done = -1; stall_left = 0;
    stalled = 1'b0; rb = '0;

    word_data  = words[0];
    word_valid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check1("idle_ready", word_ready, 1'b0);
      check1("idle_enable", chain_enable, 1'b0);
    end
    start = 1'b1;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (cyc == 0) begin
        check1("busy_rise", busy, 1'b1);
        check1("clear_entry", chain_nreset, 1'b0);
      end
      if (!chain_nreset) begin
        nclr++;
        check1("clear_ready", word_ready, 1'b0);
        check1("clear_enable", chain_enable, 1'b0);
      end
      if (chain_enable) begin
        if (nbits < cl) check1($sformatf("bit%0d", nbits), chain_data, exp_bits[nbits]);
        rb = {rb[30:0], chain_data};
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        nbits++;
        nen++;
      end else begin
        check1("quiet_data", chain_data, 1'b0);
      end
      if (done) begin
        ndone++;
        check1("done_busy", busy, 1'b0);
        if (start_pulses) start = 1'b1;
        if (after_done < 0) after_done = cyc;
      end
      if (start_pulses && chain_enable && nbits == 5) start = 1'b1;

      if (reset_after > 0 && nbits == reset_after) begin
        reset      = 1'b1;
        word_valid = 1'b0;
        @(negedge clock);
        check1("rst_word_ready", word_ready, 1'b0);
        check1("rst_chain_data", chain_data, 1'b0);
        check1("rst_chain_enable", chain_enable, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_chain_nreset", chain_nreset, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check1("post_rst_nreset", chain_nreset, 1'b1);
        check1("post_rst_busy", busy, 1'b0);
        check1("post_rst_enable", chain_enable, 1'b0);
        return;
      end

      if (after_done >= 0 && cyc >= after_done + 3) break;

      v = (idx <= nw);
      if (stall_len > 0 && idx == 1 && !stalled && word_ready) begin
        stall_left = stall_len;
        stalled    = 1'b1;
      end
      if (stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end
      if (rand_valid && $urandom_range(0, 2) == 0) v = 1'b0;
      word_valid = v;
      word_data  = words[idx > 3 ? 3 : idx];
      if (word_valid && word_ready) idx++;
    end

    checkn("enable_count", nen, cl);
    checkn("done_count", ndone, 1);
    checkn("words_accepted", idx, nw);
    checkn("clear_cycles", nclr, 2);
    check1("busy_after", busy, 1'b0);
    check1("nreset_after", chain_nreset, 1'b1);
    check1("ready_after", word_ready, 1'b0);
    if (!rand_valid) checkn("enable_span", last_en - first_en, cl - 1 + stall_len);
    checkn("readback", rb, exp_rb);
    word_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    word_valid = 1'b0; word_data = '0;
    repeat (3) @(negedge clock);
    check1("reset_word_ready", word_ready, 1'b0);
    check1("reset_chain_data", chain_data, 1'b0);
    check1("reset_chain_enable", chain_enable, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_chain_nreset", chain_nreset, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check1("nreset_after_reset", chain_nreset, 1'b1);

    // Continuous host, then a 3-cycle host stall after word 1.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h5A;
    run_load(24, 0, 1'b0, 1'b0, 0, 32'h00A53CF0);
    run_load(24, 3, 1'b0, 1'b0, 0, 32'h00A53CF0);

    // 20-bit chain: last word truncated to its upper 4 bits, 4th word refused.
    sel = 1'b1;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hAB; words[3] = 8'h55;
    run_load(20, 0, 1'b0, 1'b0, 0, 32'h000FF00A);
    sel = 1'b0;
    @(negedge clock);

    // Reset after bit 10, then a complete load.
    words[0] = 8'h96; words[1] = 8'h0F; words[2] = 8'hC3; words[3] = 8'h11;
    run_load(24, 0, 1'b0, 1'b0, 10, 32'h0);
    run_load(24, 0, 1'b0, 1'b0, 0, 32'h00960FC3);

    // Start pulses during SHIFT and in DONE must be ignored.
    run_load(24, 0, 1'b0, 1'b1, 0, 32'h00960FC3);

    // Random words with a randomly stalling host.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      run_load(24, 0, 1'b1, 1'b0, 0, {8'h00, words[0], words[1], words[2]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WORD_WIDTH, 8, width of host configuration words.
REQ-002 Parameter CHAIN_LENGTH, 24, total bits in the downstream config shift chain.
REQ-003 Parameter CLEAR_CYCLES, 2, cycles chain_nreset is held low before shifting.
REQ-004 clock  in  1  single clock; loader and chain share it.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a load.
REQ-007 word_data  in  WORD_WIDTH  host configuration word.
REQ-008 word_valid  in  1  word_data valid.
REQ-009 word_ready  out  1  loader accepts word_data this cycle.
REQ-010 chain_data  out  1  serial bit to chain config_in.
REQ-011 chain_enable  out  1  chain shift enable.
REQ-012 chain_nreset  out  1  active-low clear to chain.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  one-cycle pulse when the last chain bit is shifted.

Function
REQ-015 FSM states: IDLE, CLEAR, SHIFT, DONE.
REQ-016 IDLE: start=1 -> CLEAR; busy rises the following cycle.
REQ-017 CLEAR: chain_nreset=0 for exactly CLEAR_CYCLES cycles, then SHIFT.
REQ-018 SHIFT: a word is accepted on word_valid&word_ready; word_ready=1 only in SHIFT when the internal word buffer is empty or is emptying this cycle.
REQ-019 Bits sent MSB-first per word; one bit per cycle with chain_enable=1; chain_data valid in the same cycle as chain_enable.
REQ-020 Buffer empty in SHIFT (host underrun): chain_enable=0, chain_data=0, bit counter held; no bit lost or duplicated.
REQ-021 Back-to-back words: next word accepted during the last bit of the current word so a continuously valid host gives no enable gaps.
REQ-022 chain_enable asserted exactly CHAIN_LENGTH cycles per load; bit counter width clog2(CHAIN_LENGTH+1).
REQ-023 CHAIN_LENGTH not a multiple of WORD_WIDTH: final word contributes only its upper (CHAIN_LENGTH mod WORD_WIDTH) bits; lower bits discarded.
REQ-024 After last bit -> DONE for one cycle: done=1, busy=0 in DONE, then IDLE; no word accepted beyond ceil(CHAIN_LENGTH/WORD_WIDTH) per load.
REQ-025 start while busy or in DONE is ignored.
REQ-026 Outside SHIFT: chain_enable=0, chain_data=0, word_ready=0.
REQ-027 All outputs registered; no combinational path from inputs to chain_* outputs.

Reset
REQ-028 reset=1 at any clock edge -> IDLE, counters/buffer cleared, in-flight load abandoned.
REQ-029 Reset values: word_ready=0, chain_data=0, chain_enable=0, busy=0, done=0, chain_nreset=0.
REQ-030 chain_nreset=1 from first cycle after reset deasserts, except during CLEAR.

Structure
REQ-031 FSM state enum and default parameter values in shared package config_pkg.
REQ-032 One sub-module: config_word_serializer (load word, shift MSB-first, report empty/last-bit); FSM and counters in config_loader.

Verification (WORD_WIDTH=8, CHAIN_LENGTH=24, CLEAR_CYCLES=2)
REQ-033 start, words 0xA5,0x3C,0xF0 continuously valid -> chain_nreset low 2 cycles, then 24 consecutive enable cycles emitting 10100101 00111100 11110000, done pulse once; chain readback equals 0xA53CF0.
REQ-034 Same words, word_valid dropped 3 cycles after word 1 -> enable gap of 3 cycles after bit 8, 24 enable cycles total, identical bitstream.
REQ-035 CHAIN_LENGTH=20, words 0xFF,0x00,0xAB -> 20 enable cycles, last 4 bits 1010, 3 words accepted, fourth word_valid not accepted.
REQ-036 reset asserted after bit 10 -> next cycle all outputs at reset values, FSM IDLE; subsequent start performs complete 24-bit load.
REQ-037 start pulsed again during SHIFT and in DONE -> ignored; exactly one done and 24 enable cycles.
REQ-038 word_valid=1 while IDLE/CLEAR -> word_ready stays 0, no enable activity until SHIFT.
